data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/pipeline_types.sv | 30 +++
 rtl/data_cache_if.sv | 32 +++
 rtl/dcache_array.sv | 49 ++++
 rtl/data_cache.sv | 141 ++++++++++++++
 tb/tb_data_cache.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_types.sv
// Shared types for the data cache: FSM state encoding, geometry constants, byte-merge helper.
package pipeline_types;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } dcache_state_t;

  localparam int DCACHE_INDEX_W = 6;
  localparam int DCACHE_LINES   = 1 << DCACHE_INDEX_W;
  localparam int DCACHE_TAG_W   = 32 - DCACHE_INDEX_W - 2;

  function automatic int dcache_tag_w(input int index_w);
    return 32 - index_w - 2;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// Core-side request bus plus backing-memory bus of the data cache; slave = cache, master = core/memory.
interface data_cache_if;
  logic        ram_en;
  logic        ram_read_en;
  logic        ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic [3:0]  ram_select;
  logic        is_cache_hit;
  logic [31:0] ram_read_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  ram_en, ram_read_en, ram_write_en, ram_addr, ram_write_data, ram_select,
    input  mem_ready, mem_rdata,
    output is_cache_hit, ram_read_data,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output ram_en, ram_read_en, ram_write_en, ram_addr, ram_write_data, ram_select,
    output mem_ready, mem_rdata,
    input  is_cache_hit, ram_read_data,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/data store: combinational read, synchronous write with byte enables, sync valid clear.
// A fill write also sets valid and the tag; a non-fill write only merges data bytes.
module dcache_array #(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_data,
  input  logic               wr_en,
  input  logic               wr_fill,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_data,
  input  logic [3:0]         wr_be
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en && wr_fill) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data carry no reset; valid bits alone gate their use.
  always_ff @(posedge clk) begin
    if (wr_en && wr_fill) tag_q[wr_index] <= wr_tag;
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_q[wr_index][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-through no-write-allocate data cache; zero-latency load hits, misses/stores 3+ cycles.
// Holds mem_req until mem_ready; DCACHE_UNCACHED_EN makes 0xB------- addresses uncacheable.
module data_cache
  import pipeline_types::*;
#(
  parameter int INDEX_W = DCACHE_INDEX_W
) (
  input logic         clk,
  input logic         rst,
  data_cache_if.slave bus
);

  localparam int TAG_W = dcache_tag_w(INDEX_W);

  dcache_state_t state_q, state_d;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    sel_q;

  logic [31:0]        lookup_addr;
  logic [INDEX_W-1:0] lookup_index;
  logic [TAG_W-1:0]   lookup_tag;
  logic               lookup_cacheable;
  logic               lookup_hit;
  logic [1:0]         unused_addr_lsb;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_data;
  logic               arr_wr_en, arr_wr_fill;
  logic [31:0]        arr_wr_data;
  logic [3:0]         arr_wr_be;

  // In IDLE the live request is looked up; afterwards only the captured address matters.
  assign lookup_addr     = (state_q == IDLE) ? bus.ram_addr : addr_q;
  assign lookup_index    = lookup_addr[INDEX_W+1:2];
  assign lookup_tag      = lookup_addr[31:INDEX_W+2];
  assign unused_addr_lsb = lookup_addr[1:0];

`ifdef DCACHE_UNCACHED_EN
  assign lookup_cacheable = (lookup_addr[31:28] != 4'hB);
`else
  assign lookup_cacheable = 1'b1;
`endif

  assign lookup_hit = rd_valid && (rd_tag == lookup_tag) && lookup_cacheable;

  dcache_array #(
    .INDEX_W(INDEX_W),
    .TAG_W  (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_index(lookup_index),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (arr_wr_en && !rst),
    .wr_fill (arr_wr_fill),
    .wr_index(lookup_index),
    .wr_tag  (lookup_tag),
    .wr_data (arr_wr_data),
    .wr_be   (arr_wr_be)
  );

  always_comb begin
    state_d           = state_q;
    bus.is_cache_hit  = 1'b0;
    bus.ram_read_data = '0;
    bus.mem_req       = 1'b0;
    bus.mem_we        = 1'b0;
    bus.mem_addr      = '0;
    bus.mem_wdata     = '0;
    bus.mem_wstrb     = '0;
    arr_wr_en         = 1'b0;
    arr_wr_fill       = 1'b0;
    arr_wr_data       = bus.mem_rdata;
    arr_wr_be         = 4'hF;
    case (state_q)
      IDLE: begin
        if (bus.ram_en && bus.ram_read_en) begin
          if (lookup_hit) begin
            bus.is_cache_hit  = 1'b1;
            bus.ram_read_data = rd_data;
          end else begin
            state_d = REFILL;
          end
        end else if (bus.ram_en && bus.ram_write_en) begin
          state_d = WRITE;
        end
      end
      REFILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr_q;
        if (bus.mem_ready) begin
          arr_wr_en   = lookup_cacheable;
          arr_wr_fill = 1'b1;
          state_d     = RESP;
        end
      end
      WRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        bus.mem_wstrb = sel_q;
        if (bus.mem_ready) begin
          arr_wr_en   = lookup_hit;
          arr_wr_data = wdata_q;
          arr_wr_be   = sel_q;
          state_d     = RESP;
        end
      end
      RESP: begin
        bus.is_cache_hit  = 1'b1;
        bus.ram_read_data = rdata_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.ram_en) begin
        addr_q  <= bus.ram_addr;
        wdata_q <= bus.ram_write_data;
        sel_q   <= bus.ram_select;
      end
      if (state_q == REFILL && bus.mem_ready) rdata_q <= bus.mem_rdata;
      if (state_q == WRITE && bus.mem_ready)  rdata_q <= '0;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Randomized and directed bench for data_cache against a residency + backing-memory reference model.
module tb_data_cache;
  import pipeline_types::*;

  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_cache_if dif();

  data_cache #(.INDEX_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(dif)
  );

  int checks = 0;
  int errors = 0;

  // Reference: backing memory contents, plus which word address each cache slot currently holds.
  logic [31:0] mem_model [logic [31:0]];
  bit          res_valid [1 << IW];
  logic [31:0] res_addr  [1 << IW];

  int          mem_delay = 0;
  bit          spurious  = 1'b0;
  logic [31:0] obs_waddr, obs_wdata;
  logic [3:0]  obs_wstrb;
  int          obs_writes = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return ~a ^ 32'h1357_9BDF;
  endfunction

  function automatic bit cacheable(input logic [31:0] a);
`ifdef DCACHE_UNCACHED_EN
    return a[31:28] != 4'hB;
`else
    return 1'b1;
`endif
  endfunction

  function automatic int slot(input logic [31:0] a);
    return int'((a >> 2) % (1 << IW));
  endfunction

  function automatic bit predict_hit(input logic [31:0] a);
    return cacheable(a) && res_valid[slot(a)] && res_addr[slot(a)] == a;
  endfunction

  function automatic void model_load(input logic [31:0] a);
    if (cacheable(a)) begin
      res_valid[slot(a)] = 1'b1;
      res_addr[slot(a)]  = a;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < (1 << IW); i++) res_valid[i] = 1'b0;
  endfunction

  function automatic logic [31:0] pick_addr();
    logic [31:0] idx, tg;
    idx = $urandom_range(0, 7);
    tg  = $urandom_range(0, 3);
    if ($urandom_range(0, 9) == 0) return 32'hB000_0000 | (idx << 2);
    return (tg << (IW + 2)) | (idx << 2);
  endfunction

  // Backing memory: answers after mem_delay extra cycles, optionally pulses ready while idle.
  initial begin
    int wait_left;
    bit in_txn;
    wait_left = 0;
    in_txn    = 1'b0;
    dif.mem_ready = 1'b0;
    dif.mem_rdata = '0;
    forever begin
      @(negedge clk);
      dif.mem_ready = 1'b0;
      dif.mem_rdata = '0;
      if (dif.mem_req) begin
        if (!in_txn) begin
          in_txn    = 1'b1;
          wait_left = mem_delay;
        end
        if (wait_left == 0) begin
          dif.mem_ready = 1'b1;
          in_txn        = 1'b0;
          if (dif.mem_we) begin
            obs_waddr = dif.mem_addr;
            obs_wdata = dif.mem_wdata;
            obs_wstrb = dif.mem_wstrb;
            obs_writes++;
          end else begin
            dif.mem_rdata = mem_read(dif.mem_addr);
          end
        end else begin
          wait_left--;
        end
      end else begin
        in_txn = 1'b0;
        if (spurious) begin
          dif.mem_ready = 1'b1;
          dif.mem_rdata = $urandom;
        end
      end
    end
  end

  // Core driver: holds the request until is_cache_hit; counts cycles, mem_req cycles and bus anomalies.
  task automatic do_req(input bit load, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] sel, output logic [31:0] data, output int cycles,
                        output int reqs, output int bad);
    @(negedge clk);
    dif.ram_en         = 1'b1;
    dif.ram_read_en    = load;
    dif.ram_write_en   = !load;
    dif.ram_addr       = addr;
    dif.ram_write_data = wdata;
    dif.ram_select     = sel;
    cycles = 0;
    reqs   = 0;
    bad    = 0;
    data   = '0;
    forever begin
      #1;
      if (dif.mem_req) begin
        reqs++;
        if (dif.mem_addr !== addr || dif.mem_we !== !load) bad++;
        if (!load && (dif.mem_wdata !== wdata || dif.mem_wstrb !== sel)) bad++;
      end else if (dif.mem_we !== 1'b0 || dif.mem_addr !== '0 || dif.mem_wdata !== '0
                   || dif.mem_wstrb !== '0) begin
        bad++;
      end
      if (dif.is_cache_hit === 1'b1) begin
        data = dif.ram_read_data;
        break;
      end
      if (dif.ram_read_data !== '0) bad++;
      if (cycles >= 60) begin
        checks++;
        errors++;
        $display("FAIL req_timeout: addr %h no is_cache_hit after %0d cycles, required within 60",
                 addr, cycles);
        break;
      end
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    dif.ram_en       = 1'b0;
    dif.ram_read_en  = 1'b0;
    dif.ram_write_en = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic test_reset();
    dif.ram_en = 1'b0; dif.ram_read_en = 1'b0; dif.ram_write_en = 1'b0;
    dif.ram_addr = '0; dif.ram_write_data = '0; dif.ram_select = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dif.is_cache_hit, dif.ram_read_data, dif.mem_req, dif.mem_we, dif.mem_addr,
         dif.mem_wdata, dif.mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: hit=%b rdata=%h req=%b we=%b addr=%h, required all 0",
               dif.is_cache_hit, dif.ram_read_data, dif.mem_req, dif.mem_we, dif.mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic [31:0] d, wv;
    int cyc, rq, bad, w0;
    mem_model[32'h0000_0010] = 32'hDEAD_BEEF;
    mem_delay = 0;
    do_req(1'b1, 32'h10, '0, 4'h0, d, cyc, rq, bad);
    model_load(32'h10);
    checks++;
    if (d !== 32'hDEAD_BEEF || rq != 1 || cyc != 2 || bad != 0) begin
      errors++;
      $display("FAIL cold_load: data=%h reqs=%0d cyc=%0d bad=%0d, required DEADBEEF 1 2 0", d, rq, cyc, bad);
    end
    idle(1);
    do_req(1'b1, 32'h10, '0, 4'h0, d, cyc, rq, bad);
    checks++;
    if (d !== 32'hDEAD_BEEF || rq != 0 || cyc != 0) begin
      errors++;
      $display("FAIL warm_hit: data=%h reqs=%0d cyc=%0d, required DEADBEEF 0 0", d, rq, cyc);
    end
    idle(1);
    w0 = obs_writes;
    do_req(1'b0, 32'h10, 32'h1122_3344, 4'b0011, d, cyc, rq, bad);
    mem_model[32'h10] = byte_merge(mem_read(32'h10), 32'h1122_3344, 4'b0011);
    checks++;
    if (obs_writes != w0 + 1 || obs_wstrb !== 4'b0011 || obs_waddr !== 32'h10
        || obs_wdata !== 32'h1122_3344 || d !== '0 || rq != 1 || cyc != 2 || bad != 0) begin
      errors++;
      $display("FAIL store_hit: writes=%0d strb=%b addr=%h wdata=%h rdata=%h reqs=%0d cyc=%0d, required 1 0011 10 11223344 0 1 2",
               obs_writes - w0, obs_wstrb, obs_waddr, obs_wdata, d, rq, cyc);
    end
    idle(1);
    do_req(1'b1, 32'h10, '0, 4'h0, d, cyc, rq, bad);
    checks++;
    if (d !== 32'hDEAD_3344 || rq != 0) begin
      errors++;
      $display("FAIL merged_load: data=%h reqs=%0d, required DEAD3344 0", d, rq);
    end
    idle(1);
    wv = $urandom;
    do_req(1'b0, 32'h410, wv, 4'hF, d, cyc, rq, bad);
    mem_model[32'h410] = wv;
    idle(1);
    do_req(1'b1, 32'h10, '0, 4'h0, d, cyc, rq, bad);
    checks++;
    if (d !== 32'hDEAD_3344 || rq != 0) begin
      errors++;
      $display("FAIL store_miss_no_alloc: data=%h reqs=%0d, required DEAD3344 0", d, rq);
    end
    idle(1);
    do_req(1'b1, 32'h410, '0, 4'h0, d, cyc, rq, bad);
    model_load(32'h410);
    checks++;
    if (d !== wv || rq != 1) begin
      errors++;
      $display("FAIL conflict_load: data=%h reqs=%0d, required %h 1", d, rq, wv);
    end
    idle(1);
  endtask

  task automatic test_delayed_refill();
    logic [31:0] d;
    int cyc, rq, bad;
    mem_delay = 5;
    do_req(1'b1, 32'h2000, '0, 4'h0, d, cyc, rq, bad);
    model_load(32'h2000);
    checks++;
    if (d !== mem_read(32'h2000) || rq != 6 || cyc != 7 || bad != 0) begin
      errors++;
      $display("FAIL delayed_refill: data=%h reqs=%0d cyc=%0d bad=%0d, required %h 6 7 0",
               d, rq, cyc, bad, mem_read(32'h2000));
    end
    idle(1);
    #1;
    checks++;
    if (dif.is_cache_hit !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: hit=%b after response, required 0", dif.is_cache_hit);
    end
    mem_delay = 0;
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d;
    int cyc, rq, bad;
    mem_delay = 20;
    @(negedge clk);
    dif.ram_en = 1'b1; dif.ram_read_en = 1'b1; dif.ram_write_en = 1'b0;
    dif.ram_addr = 32'h3004;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (dif.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL refill_pending: mem_req=%b, required 1", dif.mem_req);
    end
    @(negedge clk);
    rst = 1'b1;
    dif.ram_en = 1'b0; dif.ram_read_en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({dif.is_cache_hit, dif.ram_read_data, dif.mem_req, dif.mem_we, dif.mem_addr,
         dif.mem_wdata, dif.mem_wstrb} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: hit=%b req=%b addr=%h, required all 0",
               dif.is_cache_hit, dif.mem_req, dif.mem_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    mem_delay = 0;
    do_req(1'b1, 32'h3004, '0, 4'h0, d, cyc, rq, bad);
    model_load(32'h3004);
    checks++;
    if (rq != 1 || d !== mem_read(32'h3004)) begin
      errors++;
      $display("FAIL post_abort_miss: reqs=%0d data=%h, required 1 %h", rq, d, mem_read(32'h3004));
    end
    idle(1);
    do_req(1'b1, 32'h410, '0, 4'h0, d, cyc, rq, bad);
    model_load(32'h410);
    checks++;
    if (rq != 1) begin
      errors++;
      $display("FAIL valid_cleared: reqs=%0d for previously cached line, required 1", rq);
    end
    idle(1);
  endtask

  task automatic test_uncached();
    logic [31:0] d;
    int cyc, rq, bad;
    for (int i = 0; i < 2; i++) begin
      bit exp_hit;
      exp_hit = predict_hit(32'hB000_0000);
      do_req(1'b1, 32'hB000_0000, '0, 4'h0, d, cyc, rq, bad);
      model_load(32'hB000_0000);
      checks++;
      if (rq != (exp_hit ? 0 : 1) || d !== mem_read(32'hB000_0000)) begin
        errors++;
        $display("FAIL uncached_load%0d: reqs=%0d data=%h, required %0d %h",
                 i, rq, d, exp_hit ? 0 : 1, mem_read(32'hB000_0000));
      end
      idle(1);
    end
  endtask

  task automatic test_random(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bit          load, exp_hit;
      logic [31:0] a, wv, d, exp_d;
      logic [3:0]  sel;
      int          cyc, rq, bad, w0;
      load = ($urandom_range(0, 2) != 0);
      a    = pick_addr();
      wv   = $urandom;
      sel  = 4'($urandom_range(1, 15));
      mem_delay = $urandom_range(0, 3);
      exp_hit = load && predict_hit(a);
      exp_d   = load ? mem_read(a) : 32'h0;
      w0 = obs_writes;
      do_req(load, a, wv, sel, d, cyc, rq, bad);
      checks++;
      if (d !== exp_d) begin
        errors++;
        $display("FAIL rnd_data[%0d]: addr=%h load=%b got %h, required %h", i, a, load, d, exp_d);
      end
      checks++;
      if (exp_hit ? (rq != 0 || cyc != 0) : (rq != mem_delay + 1 || cyc != mem_delay + 2)) begin
        errors++;
        $display("FAIL rnd_timing[%0d]: addr=%h hit_exp=%b reqs=%0d cyc=%0d delay=%0d",
                 i, a, exp_hit, rq, cyc, mem_delay);
      end
      checks++;
      if (bad != 0 || (!load && (obs_writes != w0 + 1 || obs_waddr !== a || obs_wdata !== wv
                                 || obs_wstrb !== sel))) begin
        errors++;
        $display("FAIL rnd_bus[%0d]: addr=%h bad=%0d waddr=%h wdata=%h strb=%b, required 0 %h %h %b",
                 i, a, bad, obs_waddr, obs_wdata, obs_wstrb, a, wv, sel);
      end
      if (load) model_load(a);
      else mem_model[a] = byte_merge(mem_read(a), wv, sel);
      if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
    mem_delay = 0;
  endtask

  task automatic test_spurious_ready();
    spurious = 1'b1;
    test_random(20, 1'b1);
    spurious = 1'b0;
  endtask

  task automatic test_back_to_back();
    test_random(40, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_delayed_refill();
    test_reset_mid_refill();
    test_uncached();
    test_random(150, 1'b1);
    test_spurious_ready();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
